// File: rtl/window_scan_ctrl.sv
// Raster-order window read sequencer: walks every channel/row/column-pair of a frame and
// issues window addresses plus border pad masks. Optional stall counter under WSC_STALL_CNT_EN.
module window_scan_ctrl #(
  parameter int IMG_ROWS = 2048,
  parameter int IMG_COLS = 2048,
  parameter int CH_NUM   = 5,
  parameter int PAD      = 2,
  parameter int LINE_GAP = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        rd_ready,
  output logic                        rd_en,
  output logic [$clog2(IMG_ROWS)-1:0] rd_row,
  output logic [$clog2(IMG_COLS)-1:0] rd_col,
  output logic [2:0]                  channel_num,
  output logic [2*PAD:0]              row_pad_mask,
  output logic [2*PAD+1:0]            col_pad_mask,
  output logic                        frame_start,
  output logic                        frame_end,
  output logic                        busy,
  output logic                        done
`ifdef WSC_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_cnt
`endif
);

  localparam int RW = $clog2(IMG_ROWS);
  localparam int CW = $clog2(IMG_COLS);
  localparam int GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [2:0]    ch;
  logic [GW-1:0] gap_cnt;

  logic last_col;
  logic last_row;
  logic last_ch;

  assign last_col = (col == CW'(IMG_COLS - 2));
  assign last_row = (row == RW'(IMG_ROWS - 1));
  assign last_ch  = (ch == 3'(CH_NUM - 1));

  // Abort beats every transition; the gap counter is loaded with LINE_GAP-1 so GAP lasts LINE_GAP cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      ch      <= '0;
      gap_cnt <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row   <= '0;
            col   <= '0;
            ch    <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (rd_ready) begin
            if (!last_col) begin
              col <= col + CW'(2);
            end else if (!last_row || !last_ch) begin
              col <= '0;
              if (!last_row) begin
                row <= row + 1'b1;
              end else begin
                row <= '0;
                ch  <= ch + 1'b1;
              end
              if (LINE_GAP == 0) begin
                state <= RUN;
              end else begin
                state   <= GAP;
                gap_cnt <= GW'(LINE_GAP - 1);
              end
            end else begin
              state <= DONE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= RUN;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_en       = (state == RUN);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign rd_row      = row;
  assign rd_col      = col;
  assign channel_num = ch;
  assign frame_start = rd_en && (row == '0) && (col == '0);
  assign frame_end   = rd_en && last_row && last_col;

  // Masks only mean something while a beat is offered, so they read zero in every other state.
  always_comb begin
    row_pad_mask = '0;
    col_pad_mask = '0;
    if (state == RUN) begin
      for (int k = 0; k < 2*PAD+1; k++)
        row_pad_mask[k] = (int'(row) + k < PAD) || (int'(row) + k - PAD > IMG_ROWS - 1);
      for (int k = 0; k < 2*PAD+2; k++)
        col_pad_mask[k] = (int'(col) + k < PAD) || (int'(col) + k - PAD > IMG_COLS - 1);
    end
  end

`ifdef WSC_STALL_CNT_EN
  logic start_acc;
  assign start_acc = (state == IDLE) && start && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       stall_cnt <= '0;
    else if (start_acc)                              stall_cnt <= '0;
    else if (rd_en && !rd_ready && stall_cnt != '1)  stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Self-checking bench for window_scan_ctrl: vector table, scoreboarded scans, reset/abort corners.
module tb_window_scan_ctrl;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int CHS  = 2;
  localparam int PADW = 2;
  localparam int GAPN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort, rd_ready;
  logic       rd_en, frame_start, frame_end, busy, done;
  logic [1:0] rd_row, rd_col;
  logic [2:0] channel_num;
  logic [4:0] row_pad_mask;
  logic [5:0] col_pad_mask;

  logic       start_b, abort_b, rd_ready_b;
  logic       rd_en_b, frame_start_b, frame_end_b, busy_b, done_b;
  logic [1:0] rd_row_b, rd_col_b;
  logic [2:0] channel_num_b;
  logic [4:0] row_pad_mask_b;
  logic [5:0] col_pad_mask_b;
`ifdef WSC_STALL_CNT_EN
  logic [31:0] stall_cnt, stall_cnt_b;
`endif

  window_scan_ctrl #(.IMG_ROWS(ROWS), .IMG_COLS(COLS), .CH_NUM(CHS), .PAD(PADW), .LINE_GAP(GAPN)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .rd_ready(rd_ready),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .channel_num(channel_num),
    .row_pad_mask(row_pad_mask), .col_pad_mask(col_pad_mask),
    .frame_start(frame_start), .frame_end(frame_end), .busy(busy), .done(done)
`ifdef WSC_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Second instance covers the no-gap, single-channel configuration.
  window_scan_ctrl #(.IMG_ROWS(ROWS), .IMG_COLS(COLS), .CH_NUM(1), .PAD(PADW), .LINE_GAP(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .rd_ready(rd_ready_b),
    .rd_en(rd_en_b), .rd_row(rd_row_b), .rd_col(rd_col_b), .channel_num(channel_num_b),
    .row_pad_mask(row_pad_mask_b), .col_pad_mask(col_pad_mask_b),
    .frame_start(frame_start_b), .frame_end(frame_end_b), .busy(busy_b), .done(done_b)
`ifdef WSC_STALL_CNT_EN
    , .stall_cnt(stall_cnt_b)
`endif
  );

  typedef struct {
    logic st, ab, rdy;
    logic en, bsy, dn, fs, fe;
    logic chk;
    logic [1:0] row, col;
    logic [2:0] ch;
  } vec_t;

  typedef struct { int ch; int row; int col; } beat_t;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r);
    start    = s;
    abort    = a;
    rd_ready = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rmask(input int r);
    logic [4:0] m;
    for (int k = 0; k < 5; k++) m[k] = (r - PADW + k < 0) || (r - PADW + k >= ROWS);
    return m;
  endfunction

  function automatic logic [5:0] cmask(input int c);
    logic [5:0] m;
    for (int k = 0; k < 6; k++) m[k] = (c - PADW + k < 0) || (c - PADW + k >= COLS);
    return m;
  endfunction

  function automatic logic [63:0] allOut();
    return 64'({rd_en, rd_row, rd_col, channel_num, row_pad_mask, col_pad_mask,
                frame_start, frame_end, busy, done});
  endfunction

  function automatic logic [63:0] beatAct();
    return 64'({channel_num, rd_row, rd_col, row_pad_mask, col_pad_mask, frame_start, frame_end});
  endfunction

  function automatic logic [63:0] beatExp(input beat_t e);
    return 64'({3'(e.ch), 2'(e.row), 2'(e.col), rmask(e.row), cmask(e.col),
                1'(e.row == 0 && e.col == 0), 1'(e.row == ROWS-1 && e.col == COLS-2)});
  endfunction

  // One full frame scan against a queue of expected beats built from nested raster loops.
  // mode 0: ready high except a stall window; mode 1: random ready.
  task automatic runScan(input int mode, input int stall_beat, input int stall_len,
                         input int abort_beat, input int start_beat);
    beat_t q[$];
    int    b, cyc, idle, stalls, stalled;
    bit    fresh, finished, seen;
    logic  r;
    for (int c = 0; c < CHS; c++)
      for (int rw = 0; rw < ROWS; rw++)
        for (int cl = 0; cl < COLS; cl += 2)
          q.push_back('{c, rw, cl});
    b = 0; cyc = 0; idle = 0; stalls = 0; stalled = 0; fresh = 1; finished = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    while (!finished && cyc < 1000) begin
      if (done) begin
        checkOutput("beat_count", 64'(b), 64'(q.size()));
        checkOutput("done_cycle", 64'(cyc + 1), 64'(q.size() + (CHS*ROWS - 1)*GAPN + 1 + stalls));
`ifdef WSC_STALL_CNT_EN
        checkOutput("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
        finished = 1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("idle_after_done", 64'({busy, done, rd_en}), 64'(0));
      end else if (rd_en) begin
        if (b >= q.size()) begin
          checkOutput("extra_beat", 64'(b), 64'(q.size()));
          finished = 1;
          applyStimulus(1'b0, 1'b1, 1'b0);
        end else begin
          if (fresh) checkOutput("gap_len", 64'(idle), 64'((b > 0 && q[b].col == 0) ? GAPN : 0));
          fresh = 0;
          idle  = 0;
          checkOutput($sformatf("beat%0d", b), beatAct(), beatExp(q[b]));
          if (b == abort_beat) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("abort_idle", 64'({rd_en, busy}), 64'(0));
            seen = 0;
            repeat (4) begin
              applyStimulus(1'b0, 1'b0, 1'b1);
              if (done || busy) seen = 1;
            end
            checkOutput("abort_no_done", 64'(seen), 64'(0));
            finished = 1;
          end else begin
            if (mode == 1) r = ($urandom_range(0, 3) != 0);
            else           r = !(b == stall_beat && stalled < stall_len);
            applyStimulus(b == start_beat, 1'b0, r);
            cyc++;
            if (r) begin b++; fresh = 1; stalled = 0; end
            else begin stalls++; stalled++; end
          end
        end
      end else begin
        idle++;
        applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        cyc++;
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL scan_timeout: got no done after %0d cycles, expected done", cyc);
      applyStimulus(1'b0, 1'b1, 1'b0);
    end
  endtask

  vec_t vecs[12];
  bit   found;
  int   b, cyc, gaps;
  bit   fin;

  initial begin
    vecs[0]  = '{1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1, 2'd0,2'd0,3'd0};
    vecs[1]  = '{1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1, 2'd0,2'd2,3'd0};
    vecs[2]  = '{1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1, 2'd1,2'd0,3'd0};
    vecs[3]  = '{1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1, 2'd1,2'd0,3'd0};
    vecs[4]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1, 2'd1,2'd0,3'd0};
    vecs[5]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1, 2'd1,2'd0,3'd0};
    vecs[6]  = '{1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1, 2'd1,2'd2,3'd0};
    vecs[7]  = '{1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1, 2'd1,2'd2,3'd0};
    vecs[8]  = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'd0,2'd0,3'd0};
    vecs[9]  = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'd0,2'd0,3'd0};
    vecs[10] = '{1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1, 2'd0,2'd0,3'd0};
    vecs[11] = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'd0,2'd0,3'd0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; rd_ready_b = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_state", allOut(), 64'(0));
`ifdef WSC_STALL_CNT_EN
    checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'(0));
`endif

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].st, vecs[i].ab, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_ctrl", i), 64'({rd_en, busy, done, frame_start, frame_end}),
                  64'({vecs[i].en, vecs[i].bsy, vecs[i].dn, vecs[i].fs, vecs[i].fe}));
      if (vecs[i].chk)
        checkOutput($sformatf("vec%0d_pos", i), 64'({rd_row, rd_col, channel_num}),
                    64'({vecs[i].row, vecs[i].col, vecs[i].ch}));
    end

    runScan(0, -1, 0, -1, -1);
    runScan(0, 3, 5, -1, -1);
    runScan(0, -1, 0, 5, -1);
    runScan(0, -1, 0, -1, -1);
    runScan(1, -1, 0, -1, 7);

    // Asynchronous reset while the scan sits in a line gap.
    applyStimulus(1'b1, 1'b0, 1'b1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (busy && !rd_en) found = 1;
      else applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("reached_gap", 64'(found), 64'(1));
    #2 reset = 1'b1;
    #1 checkOutput("async_reset_clear", allOut(), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    found = 0;
    repeat (4) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (busy || rd_en) found = 1;
    end
    checkOutput("stays_idle_after_reset", 64'(found), 64'(0));
`ifdef WSC_STALL_CNT_EN
    checkOutput("stall_cnt_after_reset", 64'(stall_cnt), 64'(0));
`endif

    // Gapless single-channel instance: eight back-to-back beats.
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    b = 0; cyc = 0; gaps = 0; fin = 0;
    while (!fin && cyc < 100) begin
      if (done_b) begin
        checkOutput("b_beat_count", 64'(b), 64'(8));
        checkOutput("b_done_cycle", 64'(cyc + 1), 64'(9));
        fin = 1;
      end else begin
        if (rd_en_b) begin
          checkOutput($sformatf("b_beat%0d", b),
                      64'({rd_row_b, rd_col_b, row_pad_mask_b, col_pad_mask_b, channel_num_b}),
                      64'({2'(b / 2), 2'((b % 2) * 2), rmask(b / 2), cmask((b % 2) * 2), 3'd0}));
          b++;
        end else begin
          gaps++;
        end
        @(posedge clk);
        #1 cyc++;
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("[TB] FAIL b_timeout: got no done after %0d cycles, expected done", cyc);
    end
    checkOutput("b_no_gaps", 64'(gaps), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected summary");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/window_scan_ctrl.md
# window_scan_ctrl

Sequencer for the radar image window-read datapath. Walks every channel of a frame buffer in raster order and, per beat, issues the physical read address of a two-column, five-row window pair plus zero-padding masks for the border. Downstream accepts beats with a valid/ready handshake. Sits between the frame-level control (start/abort) and the line-buffer/window-read logic that produces `pixel_out`.

## Interface
- `IMG_ROWS`, 2048, image rows per channel (≥ 3)
- `IMG_COLS`, 2048, image columns per channel (even, ≥ 4)
- `CH_NUM`, 5, channels per frame (1..8)
- `PAD`, 2, zero-pad border width; window is (2·PAD+1) rows
- `LINE_GAP`, 2, idle cycles inserted between consecutive rows

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  single-cycle pulse; begins a frame scan from IDLE
- `abort`  in  1  abandon scan, return to IDLE
- `rd_ready`  in  1  downstream accepts the current beat
- `rd_en`  out  1  beat valid
- `rd_row`  out  $clog2(IMG_ROWS)  window centre row
- `rd_col`  out  $clog2(IMG_COLS)  first centre column of the pair (always even)
- `channel_num`  out  3  current channel
- `row_pad_mask`  out  2·PAD+1  bit k set ⇒ row `rd_row`−PAD+k is outside the image, reads as 0
- `col_pad_mask`  out  2·PAD+2  bit k set ⇒ column `rd_col`−PAD+k is outside the image, reads as 0
- `frame_start`  out  1  high with the first beat of each channel
- `frame_end`  out  1  high with the last beat of each channel
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse when the last channel completes

## Operation
- States: IDLE, RUN, GAP, DONE.
- IDLE: `start` loads row=0, col=0, ch=0 → RUN. `start` outside IDLE is ignored.
- RUN: `rd_en`=1. On `rd_en && rd_ready`, the beat is consumed:
  - col < IMG_COLS−2 → col += 2, stay in RUN.
  - last col, not last row → col=0, row += 1 → GAP (skipped if LINE_GAP=0).
  - last col, last row, ch < CH_NUM−1 → col=0, row=0, ch += 1 → GAP.
  - last col, last row, last ch → DONE.
- GAP: `rd_en`=0 for exactly LINE_GAP cycles, counted by a gap counter, then → RUN.
- DONE: `done`=1 for one cycle → IDLE; `channel_num` holds the last value.
- Masks are combinational from the registered row/col; row range is [0, IMG_ROWS−1], column range is [0, IMG_COLS−1]. Use signed arithmetic one bit wider than the index width.
- `frame_start` = RUN && row==0 && col==0; `frame_end` = RUN && last row && last col. Both are qualified only by `rd_en`, not by `rd_ready`.
- `abort` has priority over all transitions and takes effect at the next edge: → IDLE, `rd_en`=0, no `done` pulse.

## Timing
- Reset values: state IDLE, every output 0, `rd_col`=0, `rd_row`=0, `channel_num`=0.
- Reset asserted mid-scan: all outputs clear asynchronously. The scan does not resume after reset deasserts.
- `start` sampled at edge N ⇒ `rd_en`=1 from N+1.
- Outputs are registered. While `rd_en && !rd_ready`, every output holds stable.
- Full throughput is one beat per cycle with `rd_ready` held high.
- Cycles from `start` to `done`: CH_NUM·IMG_ROWS·IMG_COLS/2 beats + (CH_NUM·IMG_ROWS−1)·LINE_GAP + 1, plus any stall cycles.

## Configuration
- `WSC_STALL_CNT_EN` defined: adds output port `stall_cnt` [31:0].
  - Increments on every cycle with `rd_en && !rd_ready`; saturates at all-ones.
  - Clears on accepted `start` and on `reset`.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
All scenarios use IMG_ROWS=4, IMG_COLS=4, CH_NUM=2, PAD=2, LINE_GAP=2 unless stated.
- Reset then `start` with `rd_ready`=1 → 16 beats, `done` 31 cycles after `start`. Beat sequence (row,col): (0,0),(0,2), gap 2, (1,0)…; `channel_num` steps 0→1 after beat 8.
- First beat → `row_pad_mask`=5'b00011, `col_pad_mask`=6'b000011, `frame_start`=1. Beat (3,2) → `row_pad_mask`=5'b11000, `col_pad_mask`=6'b110000, `frame_end`=1.
- `rd_ready` held low 5 cycles on beat (1,2) → all outputs stable for 5 cycles; with the macro defined, `stall_cnt`=5.
- `abort` on beat 6 → `rd_en`=0 and `busy`=0 next cycle, no `done`. A new `start` restarts at (0,0), ch 0.
- `start` pulsed during RUN → ignored, sequence unchanged. `reset` pulsed mid-GAP → all outputs 0 immediately, remains IDLE.
- LINE_GAP=0, CH_NUM=1 → 8 consecutive beats, `done` 9 cycles after `start`.
